// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the execute stage: RV32M operation encodings,
// mul/div FSM states and the integer datapath width.
package cpu_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } mul_mode_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } md_state_e;

endpackage

// File: rtl/div_iter_core.sv
// Unsigned restoring divider: one quotient bit per step, magnitudes in, raw
// quotient/remainder out. Signs and special cases are resolved by the caller.
module div_iter_core #(
    parameter int XLEN      = 32,
    parameter int DIV_STEPS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            last
);

    localparam int CNT_W = $clog2(DIV_STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

    logic [XLEN-1:0]  quot_r;
    logic [XLEN-1:0]  rem_r;
    logic [XLEN-1:0]  divisor_r;
    logic [CNT_W-1:0] step_cnt_r;
    logic [XLEN:0]    rem_shift_s;
    logic [XLEN:0]    diff_s;

    // Trial subtraction; diff_s[XLEN] set means the shifted remainder is below the divisor.
    always_comb begin
        rem_shift_s = {rem_r, quot_r[XLEN-1]};
        diff_s      = rem_shift_s - {1'b0, divisor_r};
    end

    // Shift-subtract iteration; the quotient register doubles as the dividend shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quot_r     <= '0;
            rem_r      <= '0;
            divisor_r  <= '0;
            step_cnt_r <= '0;
        end else if (start) begin
            quot_r     <= dividend;
            rem_r      <= '0;
            divisor_r  <= divisor;
            step_cnt_r <= '0;
        end else if (step) begin
            if (!diff_s[XLEN]) begin
                rem_r  <= diff_s[XLEN-1:0];
                quot_r <= {quot_r[XLEN-2:0], 1'b1};
            end else begin
                rem_r  <= rem_shift_s[XLEN-1:0];
                quot_r <= {quot_r[XLEN-2:0], 1'b0};
            end
            step_cnt_r <= step_cnt_r + 1'b1;
        end else begin
            quot_r     <= quot_r;
            rem_r      <= rem_r;
            divisor_r  <= divisor_r;
            step_cnt_r <= step_cnt_r;
        end
    end

    assign quotient  = quot_r;
    assign remainder = rem_r;
    assign last      = step && (step_cnt_r == LAST_STEP);

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M execute unit: 2-cycle multiplier and iterative divider.
// Optional MUL_DIV_EARLY_OUT_EN lets divide-by-zero and signed overflow bypass the iterations.
module mul_div_unit #(
    parameter int XLEN      = cpu_ctrl_pkg::XLEN,
    parameter int DIV_STEPS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      mul_mode,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    import cpu_ctrl_pkg::*;

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    md_state_e       state_r;
    logic [2:0]      mode_r;
    logic [XLEN-1:0] op_a_r;
    logic [XLEN-1:0] op_b_r;
    logic            div_load_r;

    logic              a_signed_s;
    logic              b_signed_s;
    logic [2*XLEN-1:0] a_ext_s;
    logic [2*XLEN-1:0] b_ext_s;
    logic [2*XLEN-1:0] product_s;
    logic [XLEN-1:0]   mul_res_s;

    logic            signed_div_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic [XLEN-1:0] a_mag_s;
    logic [XLEN-1:0] b_mag_s;
    logic            div_zero_s;
    logic            div_ovf_s;
    logic [XLEN-1:0] quot_fix_s;
    logic [XLEN-1:0] rem_fix_s;
    logic [XLEN-1:0] fix_res_s;

    logic            core_start_s;
    logic            core_step_s;
    logic            core_last_s;
    logic [XLEN-1:0] core_quot_s;
    logic [XLEN-1:0] core_rem_s;

    logic            accept_s;
    logic            early_out_s;

    // Operand extension: modular 2*XLEN product of the extended operands gives every MUL* variant.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (mode_r)
            MD_MULH: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            MD_MULHSU: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        a_ext_s   = {{XLEN{a_signed_s & op_a_r[XLEN-1]}}, op_a_r};
        b_ext_s   = {{XLEN{b_signed_s & op_b_r[XLEN-1]}}, op_b_r};
        product_s = a_ext_s * b_ext_s;
        if (mode_r == MD_MUL) begin
            mul_res_s = product_s[XLEN-1:0];
        end else begin
            mul_res_s = product_s[2*XLEN-1:XLEN];
        end
    end

    // Divider sign handling, special cases and final sign correction.
    always_comb begin
        signed_div_s = ~mode_r[0];
        a_neg_s      = signed_div_s & op_a_r[XLEN-1];
        b_neg_s      = signed_div_s & op_b_r[XLEN-1];
        if (a_neg_s) begin
            a_mag_s = -op_a_r;
        end else begin
            a_mag_s = op_a_r;
        end
        if (b_neg_s) begin
            b_mag_s = -op_b_r;
        end else begin
            b_mag_s = op_b_r;
        end
        div_zero_s = (op_b_r == '0);
        div_ovf_s  = signed_div_s && (op_a_r == INT_MIN) && (op_b_r == ALL_ONES);
        if (div_zero_s) begin
            quot_fix_s = ALL_ONES;
            rem_fix_s  = op_a_r;
        end else if (div_ovf_s) begin
            quot_fix_s = INT_MIN;
            rem_fix_s  = '0;
        end else begin
            if (a_neg_s ^ b_neg_s) begin
                quot_fix_s = -core_quot_s;
            end else begin
                quot_fix_s = core_quot_s;
            end
            if (a_neg_s) begin
                rem_fix_s = -core_rem_s;
            end else begin
                rem_fix_s = core_rem_s;
            end
        end
        if (mode_r[1]) begin
            fix_res_s = rem_fix_s;
        end else begin
            fix_res_s = quot_fix_s;
        end
    end

    // Launch qualification; the early-out decision uses the incoming operands.
    always_comb begin
        accept_s = start && !flush && ((state_r == S_IDLE) || (state_r == S_DONE));
`ifdef MUL_DIV_EARLY_OUT_EN
        early_out_s = (op_b == '0) ||
                      (!mul_mode[0] && (op_a == INT_MIN) && (op_b == ALL_ONES));
`else
        early_out_s = 1'b0;
`endif
        core_start_s = (state_r == S_DIV) && div_load_r;
        core_step_s  = (state_r == S_DIV) && !div_load_r;
    end

    div_iter_core #(
        .XLEN      (XLEN),
        .DIV_STEPS (DIV_STEPS)
    ) u_div_iter_core (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start_s),
        .step      (core_step_s),
        .dividend  (a_mag_s),
        .divisor   (b_mag_s),
        .quotient  (core_quot_s),
        .remainder (core_rem_s),
        .last      (core_last_s)
    );

    // Control FSM with registered busy/done/result; the first DIV cycle loads the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            mode_r     <= 3'b000;
            op_a_r     <= '0;
            op_b_r     <= '0;
            div_load_r <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
        end else begin
            done <= 1'b0;
            if (flush && (state_r != S_IDLE)) begin
                state_r    <= S_IDLE;
                busy       <= 1'b0;
                div_load_r <= 1'b0;
            end else begin
                case (state_r)
                    S_IDLE, S_DONE: begin
                        if (accept_s) begin
                            mode_r     <= mul_mode;
                            op_a_r     <= op_a;
                            op_b_r     <= op_b;
                            busy       <= 1'b1;
                            div_load_r <= 1'b1;
                            if (!mul_mode[2]) begin
                                state_r <= S_MUL;
                            end else if (early_out_s) begin
                                state_r <= S_FIX;
                            end else begin
                                state_r <= S_DIV;
                            end
                        end else begin
                            state_r <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    S_MUL: begin
                        result  <= mul_res_s;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= S_DONE;
                    end
                    S_DIV: begin
                        div_load_r <= 1'b0;
                        if (core_last_s) begin
                            state_r <= S_FIX;
                        end else begin
                            state_r <= S_DIV;
                        end
                    end
                    S_FIX: begin
                        result  <= fix_res_s;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= S_DONE;
                    end
                    default: begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: results, latency, flush,
// ignored/back-to-back starts and asynchronous reset.
module tb_mul_div_unit;

    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  mul_mode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fails  = 0;
    int lat;

`ifdef MUL_DIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 2;
`else
    localparam int SPECIAL_LAT = 35;
`endif

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mul_mode (mul_mode),
        .op_a     (op_a),
        .op_b     (op_b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Presents a start during cycle 0; returns at the cycle-1 negedge.
    task automatic launch(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
        mul_mode = m;
        op_a     = a;
        op_b     = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input int first, output int cycles);
        cycles = first;
        while (done !== 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] m, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        launch(m, a, b);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(1, lat);
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_res"}, result, exp);
        check_eq({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        mul_mode = 3'b000;
        op_a     = 32'd0;
        op_b     = 32'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Consecutive run_op calls launch in the done cycle, covering back-to-back starts.
        run_op("mulh",     MD_MULH,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 2);
        run_op("mul",      MD_MUL,    32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 2);
        run_op("mulhu",    MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
        run_op("mulhsu",   MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
        run_op("div",      MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35);
        run_op("rem",      MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35);
        run_op("div_pn",   MD_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 35);
        run_op("rem_pn",   MD_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        35);
        run_op("divu",     MD_DIVU,   32'd100,      32'd7,        32'd14,       35);
        run_op("remu",     MD_REMU,   32'd100,      32'd7,        32'd2,        35);
        run_op("divu_z",   MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, SPECIAL_LAT);
        run_op("rem_z",    MD_REM,    32'd5,        32'd0,        32'd5,        SPECIAL_LAT);
        run_op("div_negz", MD_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, SPECIAL_LAT);
        run_op("remu_z",   MD_REMU,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, SPECIAL_LAT);
        run_op("div_ovf",  MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPECIAL_LAT);
        run_op("rem_ovf",  MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        SPECIAL_LAT);
        run_op("mulhu2",   MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
        repeat (2) @(negedge clk);

        // Flush a divide at cycle 10, restart at cycle 12.
        launch(MD_DIV, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_busy", {31'd0, busy}, 32'd0);
        check_eq("flush_done", {31'd0, done}, 32'd0);
        check_eq("flush_result", result, 32'hFFFFFFFE);
        @(negedge clk);
        check_eq("flush_done12", {31'd0, done}, 32'd0);
        run_op("after_flush", MD_DIV, 32'd100, 32'd7, 32'd14, 35);
        repeat (2) @(negedge clk);

        // Flush and start together in IDLE: start is dropped.
        mul_mode = MD_MUL;
        op_a     = 32'd3;
        op_b     = 32'd3;
        start    = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check_eq("fs_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_eq("fs_done", {31'd0, done}, 32'd0);
        check_eq("fs_result", result, 32'd14);

        // A second start while busy is ignored.
        launch(MD_DIVU, 32'd200, 32'd7);
        repeat (4) @(negedge clk);
        mul_mode = MD_MUL;
        op_a     = 32'd3;
        op_b     = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, lat);
        check_eq("ign_lat", 32'(lat), 32'd35);
        check_eq("ign_res", result, 32'd28);
        @(negedge clk);
        check_eq("ign_pulse", {31'd0, done}, 32'd0);
        check_eq("ign_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a divide.
        launch(MD_DIV, 32'd200, 32'd7);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_done", {31'd0, done}, 32'd0);
        check_eq("arst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("post_rst", MD_REMU, 32'd200, 32'd7, 32'd4, 35);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
